// File: rtl/decode_148_rx.sv
// Receive side of a 74LS148-style priority-encoder link: qualifies a stable
// request, emits one fixed-width active-low strobe per request, re-arms on release.
module decode_148_rx #(
  parameter int STABLE_CYCLES = 2,
  parameter int PULSE_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A0,
  input  logic       A1,
  input  logic       A2,
  input  logic       GS,
  input  logic       EO,
  output logic       Y0,
  output logic       Y1,
  output logic       Y2,
  output logic       Y3,
  output logic       Y4,
  output logic       Y5,
  output logic       Y6,
  output logic       Y7,
  output logic [2:0] CODE,
  output logic       STROBE,
  output logic       BUSY,
  output logic       ERR
);

  // state     | meaning
  // S_IDLE    | no request seen, Y all high
  // S_QUALIFY | request present, waiting for the code to hold steady
  // S_PULSE   | driving Y[CODE] low for PULSE_CYCLES cycles
  // S_HOLDOFF | strobe done, waiting for the request to be released
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUALIFY = 2'd1;
  localparam logic [1:0] S_PULSE   = 2'd2;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_CYCLES - 1);

  logic [2:0] a_q;
  logic       gs_q;
  logic       eo_q;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [2:0] cand;
  logic [2:0] code_q;
  logic       err_q;
  logic [2:0] index;
  logic       proto_err;
  logic [7:0] y_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 3'b111;
      gs_q <= 1'b1;
      eo_q <= 1'b1;
    end else begin
      a_q  <= {A2, A1, A0};
      gs_q <= GS;
      eo_q <= EO;
    end
  end

  assign index     = ~a_q;
  // An encoder cannot report both "request present" and "no request".
  assign proto_err = ~gs_q & ~eo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      cand   <= 3'd0;
      code_q <= 3'd0;
      err_q  <= 1'b0;
    end else if (proto_err) begin
      err_q <= 1'b1;
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!gs_q) begin
            state <= S_QUALIFY;
            cand  <= index;
            cnt   <= 4'd0;
          end
        end
        S_QUALIFY: begin
          if (gs_q) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (index != cand) begin
            cand <= index;
            cnt  <= 4'd0;
          end else if (cnt == STABLE_LAST) begin
            state  <= S_PULSE;
            code_q <= cand;
            cnt    <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_PULSE: begin
          if (cnt == PULSE_LAST) begin
            state <= S_HOLDOFF;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_HOLDOFF: begin
          if (gs_q) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    y_bus = 8'hFF;
    if (state == S_PULSE) y_bus[code_q] = 1'b0;
  end

  assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y_bus;
  assign CODE   = code_q;
  assign STROBE = (state == S_PULSE) && (cnt == 4'd0);
  assign BUSY   = (state != S_IDLE);
  assign ERR    = err_q;

endmodule

// File: doc/decode_148_rx.md
Name: decode_148_rx

Overview:
- Receiving end of the 74LS148-style priority-encoder interface: consumes the active-low code A2..A0 plus GS and EO.
- Qualifies a request as stable, decodes it to a one-hot active-low strobe Y7..Y0 with fixed pulse width, and re-arms only after the request is released.
- Sits between a priority encoder and downstream interrupt/service logic in the same clock domain.

Parameters:
- STABLE_CYCLES, 2, consecutive cycles the registered code must stay unchanged with GS low before it is accepted (legal 1..15).
- PULSE_CYCLES, 3, width in cycles of the active-low Y strobe (legal 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A0, A1, A2  input  1 each  encoder code, active-low; index = ~{A2,A1,A0}
- GS  input  1  group select, active-low: some request present
- EO  input  1  enable output, active-low: encoder enabled, no request
- Y0..Y7  output  1 each  decoded strobe, active-low, at most one low at a time
- CODE  output  3  index of the last accepted request (true binary)
- STROBE  output  1  one-cycle high pulse on the first cycle of a Y strobe
- BUSY  output  1  high in QUALIFY, PULSE, HOLDOFF
- ERR  output  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, rst_n low):
  - Y0..Y7 = 1, CODE = 0, STROBE = 0, BUSY = 0, ERR = 0.
  - State = IDLE, counter = 0, input registers = {A=3'b111, GS=1, EO=1}.
  - Release is synchronous to the next clk edge.
  - Reset mid-pulse truncates the strobe immediately.
- Input stage:
  - A2..A0, GS and EO are registered once (A_q, GS_q, EO_q).
  - All decisions use the registered values; there is no combinational path from input to output.
- Index = ~A_q.
- IDLE:
  - Y all high.
  - GS_q = 0: go to QUALIFY, load cand = index, cnt = 0.
- QUALIFY:
  - GS_q = 1: return to IDLE (glitch rejected; no strobe).
  - index != cand: cand = index, cnt = 0.
  - Otherwise, cnt = STABLE_CYCLES-1: go to PULSE, CODE = cand, cnt = 0.
  - Otherwise, cnt++.
- PULSE:
  - Y[CODE] = 0, all other Y = 1.
  - STROBE = 1 on the first PULSE cycle only.
  - Runs exactly PULSE_CYCLES cycles, then goes to HOLDOFF.
  - Input changes, including GS_q rising, do not shorten or alter the pulse.
- HOLDOFF:
  - Y all high.
  - Stay until GS_q = 1, then go to IDLE. A held request therefore yields exactly one strobe.
- Latency: with GS/A valid before edge 1, Y goes low after edge 2+STABLE_CYCLES and returns high after edge 2+STABLE_CYCLES+PULSE_CYCLES.
- Error:
  - GS_q = 0 and EO_q = 0 together is illegal for the encoder.
  - In any state, this sets ERR = 1 (sticky until reset).
  - The FSM goes to IDLE and Y goes all high on the next edge; an in-progress pulse is aborted.
  - The error check takes priority over all other transitions.
- Counters are 4-bit and never wrap: they are cleared on every state entry.
- EO_q = 1 with GS_q = 1 (encoder disabled) is treated identically to no request.

Test Plan:
- Reset: hold rst_n = 0 with GS = 0, A = 3'b010 -> Y all 1, BUSY = 0, STROBE = 0, ERR = 0 throughout; after release, first strobe occurs only after full qualification.
- Basic decode, defaults: A = 3'b010 (index 5), GS = 0 held from cycle 0 -> Y5 low for cycles after edges 4..6, high after edge 7; STROBE high one cycle at entry; CODE = 5; BUSY stays high until GS = 1; exactly one strobe.
- Glitch/instability:
  - GS low for 1 cycle -> no strobe.
  - Code toggling 3'b000 <-> 3'b001 every cycle with GS = 0 -> no strobe.
  - Code then held at 3'b001 -> Y6 strobe after 2 stable cycles.
- Release during pulse: GS returns to 1 on the second PULSE cycle -> Y strobe still 3 cycles wide, then IDLE directly via HOLDOFF.
- Protocol error: GS = 0, EO = 0 during PULSE -> ERR = 1 next edge, Y all high, ERR stays 1 until rst_n pulse.
- Sweep all 8 codes with STABLE_CYCLES = 1, PULSE_CYCLES = 1 -> each Yi low exactly one cycle, matching i = ~A; never two Y low simultaneously.
